// File: rtl/control_sequencer.sv
// control_sequencer: Moore control FSM that walks the datapath through
// fetch (T0..T2) and execute (T3..T6) of register-to-register ALU
// instructions, parking in HALT on halt or undefined opcodes.
// Optional feature macro: MULDIV_EN enables the mul/div sequence through T6.
// Without it the mul/div opcodes halt at T3, and Zin_high, HIin, LOin and
// Zhighout stay 0.
module control_sequencer (
    input  logic        Clock,
    input  logic        clear,
    input  logic [31:0] IR,
    input  logic        Mem_ready,
    output logic        PCout,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        MDRout,
    output logic        MARin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin_low,
    output logic        Zin_high,
    output logic        HIin,
    output logic        LOin,
    output logic        IncPC,
    output logic        Read,
    output logic [3:0]  operation,
    output logic [15:0] Rin,
    output logic [15:0] Rout,
    output logic        Run
);

    localparam int unsigned OPC_W     = 5;
    localparam int unsigned REG_IDX_W = 4;
    localparam int unsigned NUM_REGS  = 16;
    localparam int unsigned OP_W      = 4;

    // Instruction opcodes
    localparam logic [OPC_W-1:0] OPC_ADD  = 5'b00011;
    localparam logic [OPC_W-1:0] OPC_SUB  = 5'b00100;
    localparam logic [OPC_W-1:0] OPC_AND  = 5'b00101;
    localparam logic [OPC_W-1:0] OPC_OR   = 5'b00110;
    localparam logic [OPC_W-1:0] OPC_SHR  = 5'b00111;
    localparam logic [OPC_W-1:0] OPC_SHRA = 5'b01000;
    localparam logic [OPC_W-1:0] OPC_SHL  = 5'b01001;
    localparam logic [OPC_W-1:0] OPC_ROR  = 5'b01010;
    localparam logic [OPC_W-1:0] OPC_ROL  = 5'b01011;
`ifdef MULDIV_EN
    localparam logic [OPC_W-1:0] OPC_MUL  = 5'b01111;
    localparam logic [OPC_W-1:0] OPC_DIV  = 5'b10000;
`endif

    // ALU operation select codes
    localparam logic [OP_W-1:0] OP_NONE = 4'b0000;
    localparam logic [OP_W-1:0] OP_ADD  = 4'b0001;
    localparam logic [OP_W-1:0] OP_SUB  = 4'b0010;
    localparam logic [OP_W-1:0] OP_AND  = 4'b0011;
    localparam logic [OP_W-1:0] OP_OR   = 4'b0100;
    localparam logic [OP_W-1:0] OP_SHR  = 4'b0101;
    localparam logic [OP_W-1:0] OP_SHRA = 4'b0110;
    localparam logic [OP_W-1:0] OP_SHL  = 4'b0111;
    localparam logic [OP_W-1:0] OP_ROR  = 4'b1000;
    localparam logic [OP_W-1:0] OP_ROL  = 4'b1001;
`ifdef MULDIV_EN
    localparam logic [OP_W-1:0] OP_MUL  = 4'b1010;
    localparam logic [OP_W-1:0] OP_DIV  = 4'b1011;
`endif

    typedef enum logic [2:0] {
        T0   = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        T3   = 3'd3,
        T4   = 3'd4,
        T5   = 3'd5,
        T6   = 3'd6,
        HALT = 3'd7
    } state_e;

    state_e state_q, state_d;
    // Set once T1 has already spent a cycle waiting on memory, so PCin is single-shot
    logic   t1_wait_q, t1_wait_d;

    logic [OPC_W-1:0]     opcode_c;
    logic [REG_IDX_W-1:0] ra_c;
    logic [REG_IDX_W-1:0] rb_c;
    logic [REG_IDX_W-1:0] rc_c;
    logic [OP_W-1:0]      alu_code_c;
    logic                 is_alu_c;
    logic                 is_muldiv_c;
    logic                 unused_ir_bits_c;

    assign opcode_c         = IR[31:27];
    assign ra_c             = IR[26:23];
    assign rb_c             = IR[22:19];
    assign rc_c             = IR[18:15];
    assign unused_ir_bits_c = ^IR[14:0];

    // One-hot general-register select; index 0 selects R0
    function automatic logic [NUM_REGS-1:0] reg_sel(input logic [REG_IDX_W-1:0] idx);
        reg_sel = NUM_REGS'(1) << idx;
    endfunction

    // Opcode classification and ALU operation code
    always_comb begin
        alu_code_c  = OP_NONE;
        is_alu_c    = 1'b0;
        is_muldiv_c = 1'b0;
        case (opcode_c)
            OPC_ADD:  begin alu_code_c = OP_ADD;  is_alu_c = 1'b1; end
            OPC_SUB:  begin alu_code_c = OP_SUB;  is_alu_c = 1'b1; end
            OPC_AND:  begin alu_code_c = OP_AND;  is_alu_c = 1'b1; end
            OPC_OR:   begin alu_code_c = OP_OR;   is_alu_c = 1'b1; end
            OPC_SHR:  begin alu_code_c = OP_SHR;  is_alu_c = 1'b1; end
            OPC_SHRA: begin alu_code_c = OP_SHRA; is_alu_c = 1'b1; end
            OPC_SHL:  begin alu_code_c = OP_SHL;  is_alu_c = 1'b1; end
            OPC_ROR:  begin alu_code_c = OP_ROR;  is_alu_c = 1'b1; end
            OPC_ROL:  begin alu_code_c = OP_ROL;  is_alu_c = 1'b1; end
`ifdef MULDIV_EN
            OPC_MUL:  begin alu_code_c = OP_MUL;  is_muldiv_c = 1'b1; end
            OPC_DIV:  begin alu_code_c = OP_DIV;  is_muldiv_c = 1'b1; end
`endif
            default:  alu_code_c = OP_NONE;
        endcase
    end

    // State register; clear forces T0 immediately
    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            state_q   <= T0;
            t1_wait_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            t1_wait_q <= t1_wait_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        t1_wait_d = 1'b0;
        case (state_q)
            T0:   state_d = T1;
            T1: begin
                if (Mem_ready) begin
                    state_d = T2;
                end else begin
                    state_d   = T1;
                    t1_wait_d = 1'b1;
                end
            end
            T2:   state_d = T3;
            T3:   state_d = (is_alu_c || is_muldiv_c) ? T4 : HALT;
            T4:   state_d = T5;
            T5:   state_d = is_muldiv_c ? T6 : T0;
            T6:   state_d = T0;
            HALT: state_d = HALT;
            default: state_d = T0;
        endcase
    end

    // Moore output decode from state and IR; everything held low while clear is asserted
    always_comb begin
        PCout     = 1'b0;
        Zlowout   = 1'b0;
        Zhighout  = 1'b0;
        MDRout    = 1'b0;
        MARin     = 1'b0;
        PCin      = 1'b0;
        MDRin     = 1'b0;
        IRin      = 1'b0;
        Yin       = 1'b0;
        Zin_low   = 1'b0;
        Zin_high  = 1'b0;
        HIin      = 1'b0;
        LOin      = 1'b0;
        IncPC     = 1'b0;
        Read      = 1'b0;
        operation = OP_NONE;
        Rin       = '0;
        Rout      = '0;
        Run       = 1'b1;
        case (state_q)
            T0: begin
                PCout   = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                Zin_low = 1'b1;
            end
            T1: begin
                Zlowout = 1'b1;
                PCin    = !t1_wait_q;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            T3: begin
                if (is_alu_c || is_muldiv_c) begin
                    Rout = reg_sel(rb_c);
                    Yin  = 1'b1;
                end
            end
            T4: begin
                Rout      = reg_sel(rc_c);
                Zin_low   = 1'b1;
                Zin_high  = is_muldiv_c;
                operation = alu_code_c;
            end
            T5: begin
                Zlowout = 1'b1;
                if (is_muldiv_c) begin
                    LOin = 1'b1;
                end else begin
                    Rin = reg_sel(ra_c);
                end
            end
            T6: begin
`ifdef MULDIV_EN
                Zhighout = 1'b1;
                HIin     = 1'b1;
`endif
            end
            HALT: Run = 1'b0;
            default: Run = 1'b1;
        endcase
        if (!clear) begin
            PCout     = 1'b0;
            Zlowout   = 1'b0;
            Zhighout  = 1'b0;
            MDRout    = 1'b0;
            MARin     = 1'b0;
            PCin      = 1'b0;
            MDRin     = 1'b0;
            IRin      = 1'b0;
            Yin       = 1'b0;
            Zin_low   = 1'b0;
            Zin_high  = 1'b0;
            HIin      = 1'b0;
            LOin      = 1'b0;
            IncPC     = 1'b0;
            Read      = 1'b0;
            operation = OP_NONE;
            Rin       = '0;
            Rout      = '0;
            Run       = 1'b1;
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed-vector bench for control_sequencer.
// Observed outputs are packed as {strobes[14:0], Rin, Rout, operation, Run}.
module tb_control_sequencer;

    logic        Clock = 1'b0;
    logic        clear;
    logic [31:0] IR;
    logic        Mem_ready;
    logic        PCout, Zlowout, Zhighout, MDRout;
    logic        MARin, PCin, MDRin, IRin, Yin, Zin_low, Zin_high, HIin, LOin;
    logic        IncPC, Read, Run;
    logic [3:0]  operation;
    logic [15:0] Rin, Rout;

    int checks   = 0;
    int failures = 0;

    // Strobe bit positions in the packed observation
    localparam logic [14:0] S_PCOUT   = 15'h4000;
    localparam logic [14:0] S_ZLOWOUT = 15'h2000;
    localparam logic [14:0] S_ZHIOUT  = 15'h1000;
    localparam logic [14:0] S_MDROUT  = 15'h0800;
    localparam logic [14:0] S_MARIN   = 15'h0400;
    localparam logic [14:0] S_PCIN    = 15'h0200;
    localparam logic [14:0] S_MDRIN   = 15'h0100;
    localparam logic [14:0] S_IRIN    = 15'h0080;
    localparam logic [14:0] S_YIN     = 15'h0040;
    localparam logic [14:0] S_ZINL    = 15'h0020;
    localparam logic [14:0] S_ZINH    = 15'h0010;
    localparam logic [14:0] S_HIIN    = 15'h0008;
    localparam logic [14:0] S_LOIN    = 15'h0004;
    localparam logic [14:0] S_INCPC   = 15'h0002;
    localparam logic [14:0] S_READ    = 15'h0001;

    control_sequencer dut (
        .Clock(Clock), .clear(clear), .IR(IR), .Mem_ready(Mem_ready),
        .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
        .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
        .Zin_low(Zin_low), .Zin_high(Zin_high), .HIin(HIin), .LOin(LOin),
        .IncPC(IncPC), .Read(Read), .operation(operation),
        .Rin(Rin), .Rout(Rout), .Run(Run)
    );

    always #5 Clock = ~Clock;

    function automatic logic [51:0] mk(input logic [14:0] s, input logic [15:0] rin,
                                       input logic [15:0] rout, input logic [3:0] op,
                                       input logic run);
        return {s, rin, rout, op, run};
    endfunction

    function automatic logic [51:0] observe();
        return {PCout, Zlowout, Zhighout, MDRout, MARin, PCin, MDRin, IRin, Yin,
                Zin_low, Zin_high, HIin, LOin, IncPC, Read, Rin, Rout, operation, Run};
    endfunction

    function automatic logic [31:0] mk_ir(input logic [4:0] opc, input logic [3:0] ra,
                                          input logic [3:0] rb, input logic [3:0] rc);
        return {opc, ra, rb, rc, 15'h0};
    endfunction

    localparam logic [51:0] E_ZERO = {51'h0, 1'b1};
    localparam logic [51:0] E_T0   = {S_PCOUT | S_MARIN | S_INCPC | S_ZINL, 36'h0, 1'b1};
    localparam logic [51:0] E_T1F  = {S_ZLOWOUT | S_PCIN | S_READ | S_MDRIN, 36'h0, 1'b1};
    localparam logic [51:0] E_T1W  = {S_ZLOWOUT | S_READ | S_MDRIN, 36'h0, 1'b1};
    localparam logic [51:0] E_T2   = {S_MDROUT | S_IRIN, 36'h0, 1'b1};
    localparam logic [51:0] E_HALT = 52'h0;

    // Bus-drive and Rin exclusivity on every cycle outside reset
    always @(negedge Clock) begin
        if (clear === 1'b1) begin
            checks++;
            if (($countones({PCout, Zlowout, Zhighout, MDRout}) + $countones(Rout)) > 1 ||
                $countones(Rin) > 1) begin
                failures++;
                $display("FAIL onehot t=%0t drives=%b Rout=%h Rin=%h required at most one each",
                         $time, {PCout, Zlowout, Zhighout, MDRout}, Rout, Rin);
            end
        end
    end

    // Reset pulse; returns just after release with the DUT in T0
    task automatic do_reset(input logic [31:0] ir, input logic mr);
        @(negedge Clock);
        clear     = 1'b0;
        IR        = ir;
        Mem_ready = mr;
        @(negedge Clock);
        clear = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        logic [51:0] obs;
        clear     = 1'b0;
        IR        = mk_ir(5'b00111, 4'd1, 4'd2, 4'd3);
        Mem_ready = 1'b1;
        repeat (3) @(negedge Clock);
        obs = observe();
        checks++;
        if (obs !== E_ZERO) begin
            failures++;
            $display("FAIL reset_hold got=%h exp=%h", obs, E_ZERO);
        end
        clear = 1'b1;
        #1;
        obs = observe();
        checks++;
        if (obs !== E_T0) begin
            failures++;
            $display("FAIL reset_release_t0 got=%h exp=%h", obs, E_T0);
        end
    endtask

    // shr R1 <- R2, R3 with memory always ready
    task automatic test_shr();
        logic [51:0] exp [0:6];
        logic [51:0] obs;
        do_reset(mk_ir(5'b00111, 4'd1, 4'd2, 4'd3), 1'b1);
        exp[0] = E_T0;
        exp[1] = E_T1F;
        exp[2] = E_T2;
        exp[3] = mk(S_YIN, 16'h0000, 16'h0004, 4'h0, 1'b1);
        exp[4] = mk(S_ZINL, 16'h0000, 16'h0008, 4'b0101, 1'b1);
        exp[5] = mk(S_ZLOWOUT, 16'h0002, 16'h0000, 4'h0, 1'b1);
        exp[6] = E_T0;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) @(negedge Clock);
            obs = observe();
            checks++;
            if (obs !== exp[i]) begin
                failures++;
                $display("FAIL shr cyc=%0d got=%h exp=%h", i, obs, exp[i]);
            end
        end
    endtask

    // add R4 <- R5, R6 with Mem_ready low for the first three T1 cycles
    task automatic test_mem_wait();
        logic [51:0] exp [0:9];
        logic [51:0] obs;
        do_reset(mk_ir(5'b00011, 4'd4, 4'd5, 4'd6), 1'b0);
        exp[0] = E_T0;
        exp[1] = E_T1F;
        exp[2] = E_T1W;
        exp[3] = E_T1W;
        exp[4] = E_T1W;
        exp[5] = E_T2;
        exp[6] = mk(S_YIN, 16'h0000, 16'h0020, 4'h0, 1'b1);
        exp[7] = mk(S_ZINL, 16'h0000, 16'h0040, 4'b0001, 1'b1);
        exp[8] = mk(S_ZLOWOUT, 16'h0010, 16'h0000, 4'h0, 1'b1);
        exp[9] = E_T0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge Clock);
            obs = observe();
            checks++;
            if (obs !== exp[i]) begin
                failures++;
                $display("FAIL mem_wait cyc=%0d got=%h exp=%h", i, obs, exp[i]);
            end
            if (i == 4) Mem_ready = 1'b1;
        end
    endtask

    // All nine ALU ops back to back without reset, including R0 selects
    task automatic test_back_to_back();
        logic [4:0]  opc [0:8];
        logic [3:0]  opv [0:8];
        logic [51:0] exp [0:5];
        logic [51:0] obs;
        logic [3:0]  ra, rb, rc;
        opc = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
                5'b01000, 5'b01001, 5'b01010, 5'b01011};
        opv = '{4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101,
                4'b0110, 4'b0111, 4'b1000, 4'b1001};
        for (int k = 0; k < 9; k++) begin
            ra = 4'(k);
            rb = 4'(k + 8);
            rc = 4'(15 - k);
            if (k == 0) begin
                do_reset(mk_ir(opc[k], ra, rb, rc), 1'b1);
            end else begin
                @(negedge Clock);
                IR = mk_ir(opc[k], ra, rb, rc);
                #1;
            end
            exp[0] = E_T0;
            exp[1] = E_T1F;
            exp[2] = E_T2;
            exp[3] = mk(S_YIN, 16'h0, 16'h1 << rb, 4'h0, 1'b1);
            exp[4] = mk(S_ZINL, 16'h0, 16'h1 << rc, opv[k], 1'b1);
            exp[5] = mk(S_ZLOWOUT, 16'h1 << ra, 16'h0, 4'h0, 1'b1);
            for (int i = 0; i < 6; i++) begin
                if (i > 0) @(negedge Clock);
                obs = observe();
                checks++;
                if (obs !== exp[i]) begin
                    failures++;
                    $display("FAIL alu_op%0d cyc=%0d got=%h exp=%h", k, i, obs, exp[i]);
                end
            end
        end
    endtask

    // mul (then div) sequence; halts at T3 when the feature is not built in
    task automatic test_muldiv();
        logic [51:0] exp [0:7];
        logic [51:0] obs;
        int n;
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0) do_reset(mk_ir(5'b01111, 4'd7, 4'd4, 4'd5), 1'b1);
            else           do_reset(mk_ir(5'b10000, 4'd0, 4'd15, 4'd0), 1'b1);
            exp[0] = E_T0;
            exp[1] = E_T1F;
            exp[2] = E_T2;
`ifdef MULDIV_EN
            exp[3] = mk(S_YIN, 16'h0, (pass == 0) ? 16'h0010 : 16'h8000, 4'h0, 1'b1);
            exp[4] = mk(S_ZINL | S_ZINH, 16'h0, (pass == 0) ? 16'h0020 : 16'h0001,
                        (pass == 0) ? 4'b1010 : 4'b1011, 1'b1);
            exp[5] = mk(S_ZLOWOUT | S_LOIN, 16'h0, 16'h0, 4'h0, 1'b1);
            exp[6] = mk(S_ZHIOUT | S_HIIN, 16'h0, 16'h0, 4'h0, 1'b1);
            exp[7] = E_T0;
            n = 8;
`else
            exp[3] = E_ZERO;
            exp[4] = E_HALT;
            exp[5] = E_HALT;
            exp[6] = E_HALT;
            n = 7;
`endif
            for (int i = 0; i < n; i++) begin
                if (i > 0) @(negedge Clock);
                obs = observe();
                checks++;
                if (obs !== exp[i]) begin
                    failures++;
                    $display("FAIL muldiv%0d cyc=%0d got=%h exp=%h", pass, i, obs, exp[i]);
                end
            end
        end
    endtask

    // halt opcode parks for 20 cycles, clear pulse restarts; undefined opcode also halts
    task automatic test_halt();
        logic [51:0] exp [0:23];
        logic [51:0] obs;
        do_reset(mk_ir(5'b11011, 4'd1, 4'd2, 4'd3), 1'b1);
        exp[0] = E_T0;
        exp[1] = E_T1F;
        exp[2] = E_T2;
        exp[3] = E_ZERO;
        for (int i = 4; i < 24; i++) exp[i] = E_HALT;
        for (int i = 0; i < 24; i++) begin
            if (i > 0) @(negedge Clock);
            obs = observe();
            checks++;
            if (obs !== exp[i]) begin
                failures++;
                $display("FAIL halt cyc=%0d got=%h exp=%h", i, obs, exp[i]);
            end
        end
        #2;
        clear = 1'b0;
        #1;
        obs = observe();
        checks++;
        if (obs !== E_ZERO) begin
            failures++;
            $display("FAIL halt_clear got=%h exp=%h", obs, E_ZERO);
        end
        @(negedge Clock);
        IR    = mk_ir(5'b00001, 4'd3, 4'd3, 4'd3);
        clear = 1'b1;
        #1;
        exp[0] = E_T0;
        exp[1] = E_T1F;
        exp[2] = E_T2;
        exp[3] = E_ZERO;
        exp[4] = E_HALT;
        exp[5] = E_HALT;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge Clock);
            obs = observe();
            checks++;
            if (obs !== exp[i]) begin
                failures++;
                $display("FAIL undef cyc=%0d got=%h exp=%h", i, obs, exp[i]);
            end
        end
    endtask

    // clear dropped in the middle of T4, between clock edges
    task automatic test_async_clear();
        logic [51:0] exp [0:4];
        logic [51:0] obs;
        do_reset(mk_ir(5'b00110, 4'd2, 4'd3, 4'd9), 1'b1);
        exp[0] = E_T0;
        exp[1] = E_T1F;
        exp[2] = E_T2;
        exp[3] = mk(S_YIN, 16'h0, 16'h0008, 4'h0, 1'b1);
        exp[4] = mk(S_ZINL, 16'h0, 16'h0200, 4'b0100, 1'b1);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge Clock);
            obs = observe();
            checks++;
            if (obs !== exp[i]) begin
                failures++;
                $display("FAIL async_pre cyc=%0d got=%h exp=%h", i, obs, exp[i]);
            end
        end
        #2;
        clear = 1'b0;
        #1;
        obs = observe();
        checks++;
        if (obs !== E_ZERO) begin
            failures++;
            $display("FAIL async_clear got=%h exp=%h", obs, E_ZERO);
        end
        @(negedge Clock);
        clear = 1'b1;
        #1;
        obs = observe();
        checks++;
        if (obs !== E_T0) begin
            failures++;
            $display("FAIL async_restart_t0 got=%h exp=%h", obs, E_T0);
        end
        @(negedge Clock);
        obs = observe();
        checks++;
        if (obs !== E_T1F) begin
            failures++;
            $display("FAIL async_restart_t1 got=%h exp=%h", obs, E_T1F);
        end
    endtask

    initial begin
        test_reset();
        test_shr();
        test_mem_wait();
        test_back_to_back();
        test_muldiv();
        test_halt();
        test_async_clear();
        @(negedge Clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
